// File: rtl/ram_moc_responder_if.sv
// Bus between the control unit (master) and the memory responder (slave).
// AlignErr exists only when MEM_ALIGN_CHK_EN is defined.
interface ram_moc_responder_if #(
  parameter int ADDR_W = 9
);
  logic              MOV;
  logic              ReadWrite;
  logic [1:0]        Size;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
`ifdef MEM_ALIGN_CHK_EN
  logic              AlignErr;
`endif

  modport master (
    output MOV, ReadWrite, Size, Address, DataIn,
`ifdef MEM_ALIGN_CHK_EN
    input  AlignErr,
`endif
    input  DataOut, MOC
  );

  modport slave (
    input  MOV, ReadWrite, Size, Address, DataIn,
`ifdef MEM_ALIGN_CHK_EN
    output AlignErr,
`endif
    output DataOut, MOC
  );
endinterface

// File: rtl/ram_moc_responder.sv
// Byte-addressed big-endian memory answering the MOV/MOC handshake with programmable latency.
// Optional MEM_ALIGN_CHK_EN: misaligned accesses are refused and flagged on AlignErr.
module ram_moc_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  ram_moc_responder_if.slave bus
);

  localparam int ROW_W = ADDR_W - 2;
  localparam int DEPTH = 1 << ROW_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              rw_reg, rw_next;
  logic [1:0]        size_reg, size_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       dataout_reg, dataout_next;
  logic              moc_reg, moc_next;
`ifdef MEM_ALIGN_CHK_EN
  logic              alignerr_reg, alignerr_next;
`endif

  logic              is_word;
  logic              is_half;
  logic              misaligned;
  logic              access_ok;
  logic              do_access;
  logic [ROW_W-1:0]  rd_row;
  logic [ROW_W-1:0]  acc_row;
  logic [7:0]        lane_rd [4];
  logic [31:0]       rd_fmt;

  // Size 11 is reserved and behaves as a word
  assign is_word = size_reg[1];
  assign is_half = (size_reg == 2'b01);
  assign misaligned = is_word ? (addr_reg[1:0] != 2'b00) :
                      is_half ? addr_reg[0] : 1'b0;

`ifdef MEM_ALIGN_CHK_EN
  assign access_ok = ~misaligned;
`else
  assign access_ok = 1'b1;
`endif

  assign do_access = (state_reg == BUSY) && bus.MOV && (cnt_reg == 4'd0);
  assign acc_row   = addr_reg[ADDR_W-1:2];

  // While idle the read port follows the live address so the row is ready even at LATENCY=0
  assign rd_row = (state_reg == IDLE) ? bus.Address[ADDR_W-1:2] : acc_row;

  // Four byte lanes; lane 0 holds the most significant (lowest address) byte of a word
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);

      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rd_q_reg;
      logic       lane_sel;
      logic       lane_we;
      logic [7:0] lane_wdata;

      assign lane_sel = is_word
                      | (is_half & (addr_reg[1] == LANE[1]))
                      | (~is_word & ~is_half & (addr_reg[1:0] == LANE));

      // Reset gating keeps an in-flight write from committing on a reset edge
      assign lane_we = Reset_n & do_access & ~rw_reg & access_ok & lane_sel;

      assign lane_wdata = is_word ? wdata_reg[31-8*gi -: 8] :
                          is_half ? (LANE[0] ? wdata_reg[7:0] : wdata_reg[15:8]) :
                                    wdata_reg[7:0];

      always_ff @(posedge Clk) begin
        if (lane_we) begin
          mem[acc_row] <= lane_wdata;
        end
        rd_q_reg <= mem[rd_row];
      end

      assign lane_rd[gi] = rd_q_reg;
    end
  endgenerate

  always_comb begin
    rd_fmt = {24'b0, lane_rd[addr_reg[1:0]]};
    if (is_word) begin
      rd_fmt = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
    end else if (is_half) begin
      rd_fmt = addr_reg[1] ? {16'b0, lane_rd[2], lane_rd[3]} :
                             {16'b0, lane_rd[0], lane_rd[1]};
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rw_next      = rw_reg;
    size_next    = size_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    dataout_next = dataout_reg;
    moc_next     = moc_reg;
`ifdef MEM_ALIGN_CHK_EN
    alignerr_next = alignerr_reg;
`endif

    case (state_reg)
      IDLE: begin
        moc_next = 1'b0;
        if (bus.MOV) begin
          rw_next    = bus.ReadWrite;
          size_next  = bus.Size;
          addr_next  = bus.Address;
          wdata_next = bus.DataIn;
          cnt_next   = 4'(LATENCY);
          state_next = BUSY;
        end
      end

      BUSY: begin
        if (!bus.MOV) begin
          // Requester gave up: leave without touching memory or DataOut
          state_next = IDLE;
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          moc_next   = 1'b1;
          state_next = DONE;
          if (rw_reg && access_ok) begin
            dataout_next = rd_fmt;
          end
`ifdef MEM_ALIGN_CHK_EN
          alignerr_next = misaligned;
`endif
        end
      end

      DONE: begin
        if (!bus.MOV) begin
          moc_next   = 1'b0;
          state_next = IDLE;
`ifdef MEM_ALIGN_CHK_EN
          alignerr_next = 1'b0;
`endif
        end
      end

      default: begin
        state_next = IDLE;
        moc_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      rw_reg      <= 1'b0;
      size_reg    <= 2'b00;
      addr_reg    <= '0;
      wdata_reg   <= 32'd0;
      dataout_reg <= 32'd0;
      moc_reg     <= 1'b0;
`ifdef MEM_ALIGN_CHK_EN
      alignerr_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rw_reg      <= rw_next;
      size_reg    <= size_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      dataout_reg <= dataout_next;
      moc_reg     <= moc_next;
`ifdef MEM_ALIGN_CHK_EN
      alignerr_reg <= alignerr_next;
`endif
    end
  end

  assign bus.DataOut = dataout_reg;
  assign bus.MOC     = moc_reg;
`ifdef MEM_ALIGN_CHK_EN
  assign bus.AlignErr = alignerr_reg;
`endif

endmodule

// File: tb/tb_ram_moc_responder.sv
// Directed bench for ram_moc_responder (ADDR_W=9, LATENCY=2); expectations are hand-computed.
module tb_ram_moc_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  int          r_lat;
  logic [31:0] r_dout;
  logic        r_ae;
  logic        r_held;
  logic        r_moc_after;
  logic        r_ae_after;

  ram_moc_responder_if #(.ADDR_W(9)) bus ();

  ram_moc_responder #(.ADDR_W(9), .LATENCY(2)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ae_now();
`ifdef MEM_ALIGN_CHK_EN
    return bus.AlignErr;
`else
    return 1'b0;
`endif
  endfunction

  // One full handshake; inputs are scrambled after capture to prove they are latched
  task automatic access(input logic rw, input logic [1:0] sz, input logic [8:0] addr,
                        input logic [31:0] din, input int hold);
    @(negedge clk);
    bus.MOV = 1'b1; bus.ReadWrite = rw; bus.Size = sz; bus.Address = addr; bus.DataIn = din;
    r_lat  = -1;
    r_held = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        bus.ReadWrite = ~rw; bus.Size = ~sz; bus.Address = ~addr; bus.DataIn = ~din;
      end
      if (bus.MOC === 1'b1) begin
        r_lat = n;
        break;
      end
    end
    r_dout = bus.DataOut;
    r_ae   = ae_now();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (bus.MOC !== 1'b1 || bus.DataOut !== r_dout) r_held = 1'b0;
    end
    @(negedge clk);
    bus.MOV = 1'b0;
    @(posedge clk); #1;
    r_moc_after = bus.MOC;
    r_ae_after  = ae_now();
    $display("txn %s size=%0d addr=0x%03h din=0x%08h lat=%0d dout=0x%08h ae=%0b",
             rw ? "RD" : "WR", sz, addr, din, r_lat, r_dout, r_ae);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.MOV = 1'b0; bus.ReadWrite = 1'b0; bus.Size = 2'b00; bus.Address = '0; bus.DataIn = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.MOC !== 1'b0) begin failures++; $display("FAIL reset_moc: got %b expected 0", bus.MOC); end
    checks++; if (bus.DataOut !== 32'd0) begin failures++; $display("FAIL reset_dout: got 0x%08h expected 0x00000000", bus.DataOut); end
`ifdef MEM_ALIGN_CHK_EN
    checks++; if (bus.AlignErr !== 1'b0) begin failures++; $display("FAIL reset_ae: got %b expected 0", bus.AlignErr); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_rw();
    access(1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 0);
    checks++; if (r_lat !== 3) begin failures++; $display("FAIL wr_word_lat: got %0d edges expected 3", r_lat); end
    checks++; if (r_dout !== 32'h0) begin failures++; $display("FAIL wr_word_dout: got 0x%08h expected 0x00000000", r_dout); end
    checks++; if (r_moc_after !== 1'b0) begin failures++; $display("FAIL wr_word_moc_drop: got %b expected 0", r_moc_after); end
    checks++; if (r_ae !== 1'b0) begin failures++; $display("FAIL wr_word_ae: got %b expected 0", r_ae); end
    access(1'b1, 2'b10, 9'h010, 32'h0, 0);
    checks++; if (r_lat !== 3) begin failures++; $display("FAIL rd_word_lat: got %0d edges expected 3", r_lat); end
    checks++; if (r_dout !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_word: got 0x%08h expected 0xdeadbeef", r_dout); end
  endtask

  task automatic test_sub_word();
    access(1'b1, 2'b00, 9'h011, 32'h0, 0);
    checks++; if (r_dout !== 32'h000000AD) begin failures++; $display("FAIL rd_byte_011: got 0x%08h expected 0x000000ad", r_dout); end
    access(1'b1, 2'b01, 9'h012, 32'h0, 0);
    checks++; if (r_dout !== 32'h0000BEEF) begin failures++; $display("FAIL rd_half_012: got 0x%08h expected 0x0000beef", r_dout); end
    access(1'b1, 2'b00, 9'h010, 32'h0, 0);
    checks++; if (r_dout !== 32'h000000DE) begin failures++; $display("FAIL rd_byte_010: got 0x%08h expected 0x000000de", r_dout); end
    access(1'b1, 2'b01, 9'h010, 32'h0, 0);
    checks++; if (r_dout !== 32'h0000DEAD) begin failures++; $display("FAIL rd_half_010: got 0x%08h expected 0x0000dead", r_dout); end
  endtask

  task automatic test_partial_write();
    access(1'b0, 2'b00, 9'h013, 32'hAABBCC55, 0);
    checks++; if (r_dout !== 32'h0000DEAD) begin failures++; $display("FAIL wr_byte_dout: got 0x%08h expected 0x0000dead", r_dout); end
    access(1'b1, 2'b10, 9'h010, 32'h0, 0);
    checks++; if (r_dout !== 32'hDEADBE55) begin failures++; $display("FAIL rd_after_byte_wr: got 0x%08h expected 0xdeadbe55", r_dout); end
    access(1'b0, 2'b10, 9'h014, 32'h00000000, 0);
    access(1'b0, 2'b01, 9'h016, 32'hFFFF1234, 0);
    access(1'b1, 2'b10, 9'h014, 32'h0, 0);
    checks++; if (r_dout !== 32'h00001234) begin failures++; $display("FAIL rd_after_half_wr: got 0x%08h expected 0x00001234", r_dout); end
  endtask

  task automatic test_abort();
    logic moc_seen;
    access(1'b0, 2'b10, 9'h020, 32'hCAFEF00D, 0);
    access(1'b1, 2'b10, 9'h020, 32'h0, 0);
    checks++; if (r_dout !== 32'hCAFEF00D) begin failures++; $display("FAIL rd_020_pre: got 0x%08h expected 0xcafef00d", r_dout); end
    @(negedge clk);
    bus.MOV = 1'b1; bus.ReadWrite = 1'b0; bus.Size = 2'b10; bus.Address = 9'h020; bus.DataIn = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.MOV = 1'b0;
    moc_seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.MOC !== 1'b0) moc_seen = 1'b1;
    end
    $display("txn WR-ABORT size=2 addr=0x020 din=0x12345678 dout=0x%08h", bus.DataOut);
    checks++; if (moc_seen !== 1'b0) begin failures++; $display("FAIL abort_moc: got MOC high expected low"); end
    checks++; if (bus.DataOut !== 32'hCAFEF00D) begin failures++; $display("FAIL abort_dout: got 0x%08h expected 0xcafef00d", bus.DataOut); end
    access(1'b1, 2'b10, 9'h020, 32'h0, 0);
    checks++; if (r_dout !== 32'hCAFEF00D) begin failures++; $display("FAIL rd_020_post_abort: got 0x%08h expected 0xcafef00d", r_dout); end
  endtask

  task automatic test_reset_busy();
    access(1'b0, 2'b10, 9'h030, 32'h11223344, 0);
    access(1'b1, 2'b10, 9'h030, 32'h0, 0);
    checks++; if (r_dout !== 32'h11223344) begin failures++; $display("FAIL rd_030_pre: got 0x%08h expected 0x11223344", r_dout); end
    @(negedge clk);
    bus.MOV = 1'b1; bus.ReadWrite = 1'b0; bus.Size = 2'b10; bus.Address = 9'h030; bus.DataIn = 32'h99999999;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("txn WR-RESET size=2 addr=0x030 din=0x99999999 moc=%b dout=0x%08h", bus.MOC, bus.DataOut);
    checks++; if (bus.MOC !== 1'b0) begin failures++; $display("FAIL rst_busy_moc: got %b expected 0", bus.MOC); end
    checks++; if (bus.DataOut !== 32'd0) begin failures++; $display("FAIL rst_busy_dout: got 0x%08h expected 0x00000000", bus.DataOut); end
    @(negedge clk);
    bus.MOV = 1'b0;
    rst_n = 1'b1;
    access(1'b1, 2'b10, 9'h030, 32'h0, 0);
    checks++; if (r_dout !== 32'h11223344) begin failures++; $display("FAIL rd_030_post_rst: got 0x%08h expected 0x11223344", r_dout); end
    access(1'b1, 2'b10, 9'h010, 32'h0, 0);
    checks++; if (r_dout !== 32'hDEADBE55) begin failures++; $display("FAIL rd_010_post_rst: got 0x%08h expected 0xdeadbe55", r_dout); end
  endtask

  task automatic test_alignment();
    logic [31:0] exp_w, exp_h, exp_after_wr;
    logic        exp_ae;
`ifdef MEM_ALIGN_CHK_EN
    exp_w = 32'h000000A1; exp_h = 32'h000000A1; exp_after_wr = 32'hA1B2C3D4; exp_ae = 1'b1;
`else
    exp_w = 32'hA1B2C3D4; exp_h = 32'h0000C3D4; exp_after_wr = 32'h00000000; exp_ae = 1'b0;
`endif
    access(1'b0, 2'b10, 9'h1FC, 32'hA1B2C3D4, 0);
    access(1'b1, 2'b00, 9'h1FC, 32'h0, 0);
    checks++; if (r_dout !== 32'h000000A1) begin failures++; $display("FAIL rd_byte_1fc: got 0x%08h expected 0x000000a1", r_dout); end
    access(1'b1, 2'b10, 9'h1FE, 32'h0, 0);
    checks++; if (r_lat !== 3) begin failures++; $display("FAIL mis_word_lat: got %0d edges expected 3", r_lat); end
    checks++; if (r_dout !== exp_w) begin failures++; $display("FAIL mis_word_1fe: got 0x%08h expected 0x%08h", r_dout, exp_w); end
    checks++; if (r_ae !== exp_ae) begin failures++; $display("FAIL mis_word_ae: got %b expected %b", r_ae, exp_ae); end
    checks++; if (r_ae_after !== 1'b0) begin failures++; $display("FAIL mis_word_ae_clear: got %b expected 0", r_ae_after); end
    access(1'b1, 2'b01, 9'h1FF, 32'h0, 0);
    checks++; if (r_dout !== exp_h) begin failures++; $display("FAIL mis_half_1ff: got 0x%08h expected 0x%08h", r_dout, exp_h); end
    checks++; if (r_ae !== exp_ae) begin failures++; $display("FAIL mis_half_ae: got %b expected %b", r_ae, exp_ae); end
    access(1'b0, 2'b10, 9'h1FD, 32'h00000000, 0);
    access(1'b1, 2'b10, 9'h1FC, 32'h0, 0);
    checks++; if (r_dout !== exp_after_wr) begin failures++; $display("FAIL mis_word_wr_1fd: got 0x%08h expected 0x%08h", r_dout, exp_after_wr); end
  endtask

  task automatic test_back_to_back();
    access(1'b1, 2'b10, 9'h010, 32'h0, 3);
    checks++; if (r_held !== 1'b1) begin failures++; $display("FAIL done_hold: got MOC/DataOut changed while MOV held, expected steady"); end
    checks++; if (r_dout !== 32'hDEADBE55) begin failures++; $display("FAIL b2b_first: got 0x%08h expected 0xdeadbe55", r_dout); end
    access(1'b1, 2'b10, 9'h030, 32'h0, 0);
    checks++; if (r_lat !== 3) begin failures++; $display("FAIL b2b_lat: got %0d edges expected 3", r_lat); end
    checks++; if (r_dout !== 32'h11223344) begin failures++; $display("FAIL b2b_second: got 0x%08h expected 0x11223344", r_dout); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_word_rw();
    test_sub_word();
    test_partial_write();
    test_abort();
    test_reset_busy();
    test_alignment();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
